pa_fmau_frac_rnd: RTL

//  Single-precision FMUL normalize/round stage, directly downstream of the 24x24 significand multiplier.
//  EX2: normalizes the 48-bit product, applies subnormal right-shift, collects guard/sticky.

---
 rtl/pa_fmau_pkg.sv | 35 +++
 rtl/pa_fmau_rnd_inc.sv | 29 ++
 rtl/pa_fmau_frac_rnd.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/pa_fmau_pkg.sv
// Shared constants and rounding-mode encodings for the FMUL normalize/round stage.
package pa_fmau_pkg;

  localparam int SINGLE_FRAC = 23;
  localparam int SINGLE_EXPN = 8;
  localparam int EXPN_W      = 10;
  localparam int EXP_BIAS    = 127;

  // Largest biased exponent; anything at or above it has overflowed.
  localparam logic [EXPN_W-1:0] EXP_OVF = 10'd255;

  // Magnitude encodings (sign bit supplied separately).
  localparam logic [30:0] MAG_MAX_FINITE = 31'h7F7F_FFFF;
  localparam logic [30:0] MAG_INF        = 31'h7F80_0000;

  typedef enum logic [2:0] {
    RM_RNE = 3'd0,
    RM_RTZ = 3'd1,
    RM_RDN = 3'd2,
    RM_RUP = 3'd3,
    RM_RMM = 3'd4
  } rm_e;

  // Unused encodings 5-7 fall back to round-to-nearest-even.
  function automatic rm_e rm_decode(input logic [2:0] rm);
    case (rm)
      3'd1:    rm_decode = RM_RTZ;
      3'd2:    rm_decode = RM_RDN;
      3'd3:    rm_decode = RM_RUP;
      3'd4:    rm_decode = RM_RMM;
      default: rm_decode = RM_RNE;
    endcase
  endfunction

endpackage

// File: rtl/pa_fmau_rnd_inc.sv
// Rounding increment decision and incremented significand for the EX3 stage.
module pa_fmau_rnd_inc
  import pa_fmau_pkg::*;
(
  input  rm_e         i_rm,
  input  logic        i_sign,
  input  logic        i_lsb,
  input  logic        i_g,
  input  logic        i_s,
  input  logic [23:0] i_mant,
  output logic        o_inc,
  output logic [24:0] o_mant_r
);

  // Pick the increment from the rounding mode, then add it with one carry bit.
  always_comb begin
    o_inc = 1'b0;
    case (i_rm)
      RM_RNE:  o_inc = i_g & (i_s | i_lsb);
      RM_RTZ:  o_inc = 1'b0;
      RM_RDN:  o_inc = i_sign & (i_g | i_s);
      RM_RUP:  o_inc = ~i_sign & (i_g | i_s);
      RM_RMM:  o_inc = i_g;
      default: o_inc = i_g & (i_s | i_lsb);
    endcase
    o_mant_r = {1'b0, i_mant} + {24'd0, o_inc};
  end

endmodule

// File: rtl/pa_fmau_frac_rnd.sv
// FMUL normalize (EX2) and round/pack (EX3) stage following the 24x24 significand multiplier.
module pa_fmau_frac_rnd
  import pa_fmau_pkg::*;
(
  input  logic        forever_cpuclk,
  input  logic        cpurst,
  input  logic [47:0] ex2_mult_data,
  input  logic [9:0]  ex2_expn,
  input  logic        ex2_sign,
  input  logic [2:0]  ex2_rm,
  input  logic        ex2_vld,
  input  logic        ctrl_dp_ex2_inst_pipe_down,
  input  logic        ctrl_xx_ex2_warm_up,
  input  logic        ctrl_xx_ex3_stall,
  input  logic        ctrl_xx_flush,
  output logic        ex3_vld,
  output logic [31:0] ex3_result,
  output logic        ex3_flag_of,
  output logic        ex3_flag_uf,
  output logic        ex3_flag_nx
);

  // EX2 working signals
  logic [23:0]        w_nrm_mant;
  logic               w_nrm_g;
  logic               w_nrm_s;
  logic signed [10:0] w_nrm_e;
  logic signed [10:0] w_sh_raw;
  logic [4:0]         w_shamt;
  logic               w_subn;
  logic [50:0]        w_sh_vec;
  logic [23:0]        w_ex2_mant;
  logic               w_ex2_g;
  logic               w_ex2_s;
  logic [9:0]         w_ex2_e;
  logic               w_ex2_load;

  // EX3 registers
  logic               r_ex3_vld;
  logic [23:0]        r_mant;
  logic               r_g;
  logic               r_s;
  logic [9:0]         r_e;
  logic               r_sign;
  rm_e                r_rm;
  logic               r_zero;

  // EX3 working signals
  logic               w_inc;
  logic [24:0]        w_mant_r;
  logic [23:0]        w_mant_f;
  logic [9:0]         w_e_post;
  logic               w_of;
  logic               w_nx;
  logic               w_uf;
  logic               w_use_max;
  logic [31:0]        w_result;

  // Normalize the product so the hidden bit sits at mant[23], extending the exponent to 11 bits
  // so that expn+1 cannot wrap.
  always_comb begin
    if (ex2_mult_data[47]) begin
      w_nrm_mant = ex2_mult_data[47:24];
      w_nrm_g    = ex2_mult_data[23];
      w_nrm_s    = |ex2_mult_data[22:0];
      w_nrm_e    = $signed({ex2_expn[9], ex2_expn}) + 11'sd1;
    end else begin
      w_nrm_mant = ex2_mult_data[46:23];
      w_nrm_g    = ex2_mult_data[22];
      w_nrm_s    = |ex2_mult_data[21:0];
      w_nrm_e    = $signed({ex2_expn[9], ex2_expn});
    end
  end

  // Subnormal denormalization: shift {mant,g} right by min(1-e,26); the 26 trailing zero bits
  // catch everything shifted out so it can be folded into sticky.
  always_comb begin
    w_subn   = (w_nrm_e <= 11'sd0);
    w_sh_raw = 11'sd1 - w_nrm_e;
    w_shamt  = 5'd0;
    if (w_subn) begin
      if (w_sh_raw > 11'sd26) w_shamt = 5'd26;
      else                    w_shamt = w_sh_raw[4:0];
    end
    w_sh_vec   = {w_nrm_mant, w_nrm_g, 26'd0} >> w_shamt;
    w_ex2_mant = w_sh_vec[50:27];
    w_ex2_g    = w_sh_vec[26];
    w_ex2_s    = w_nrm_s | (|w_sh_vec[25:0]);
    w_ex2_e    = w_subn ? 10'd0 : w_nrm_e[9:0];
  end

  assign w_ex2_load = (ctrl_dp_ex2_inst_pipe_down & ~ctrl_xx_ex3_stall) | ctrl_xx_ex2_warm_up;

  // EX3 valid bit: flush beats stall, stall holds, otherwise follow the advancing EX2 instruction.
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst)                 r_ex3_vld <= 1'b0;
    else if (ctrl_xx_flush)     r_ex3_vld <= 1'b0;
    else if (ctrl_xx_ex3_stall) r_ex3_vld <= r_ex3_vld;
    else                        r_ex3_vld <= ex2_vld & ctrl_dp_ex2_inst_pipe_down;
  end

  // EX3 data bank, deliberately without reset; contents are only visible while valid.
  always_ff @(posedge forever_cpuclk) begin
    if (w_ex2_load) begin
      r_mant <= w_ex2_mant;
      r_g    <= w_ex2_g;
      r_s    <= w_ex2_s;
      r_e    <= w_ex2_e;
      r_sign <= ex2_sign;
      r_rm   <= rm_decode(ex2_rm);
      r_zero <= (ex2_mult_data == 48'd0);
    end
  end

  pa_fmau_rnd_inc u_rnd_inc (
    .i_rm     (r_rm),
    .i_sign   (r_sign),
    .i_lsb    (r_mant[0]),
    .i_g      (r_g),
    .i_s      (r_s),
    .i_mant   (r_mant),
    .o_inc    (w_inc),
    .o_mant_r (w_mant_r)
  );

  // Post-round renormalization: a carry out bumps the exponent, and a subnormal that rounds up
  // into the hidden bit becomes the smallest normal.
  always_comb begin
    if (w_mant_r[24]) begin
      w_mant_f = w_mant_r[24:1];
      w_e_post = r_e + 10'd1;
    end else begin
      w_mant_f = w_mant_r[23:0];
      if ((r_e == 10'd0) && w_inc && w_mant_r[23]) w_e_post = 10'd1;
      else                                         w_e_post = r_e;
    end
  end

  // Overflow/inexact/underflow flags and IEEE packing; directed rounding toward zero saturates
  // to max-finite instead of infinity.
  always_comb begin
    w_of      = (w_e_post >= EXP_OVF);
    w_nx      = r_g | r_s | w_of;
    w_uf      = w_nx & (w_e_post == 10'd0);
    w_use_max = (r_rm == RM_RTZ) | ((r_rm == RM_RDN) & ~r_sign) | ((r_rm == RM_RUP) & r_sign);
    w_result  = {r_sign, w_e_post[SINGLE_EXPN-1:0], w_mant_f[SINGLE_FRAC-1:0]};
    if (r_zero) begin
      w_result = {r_sign, 31'd0};
      w_of     = 1'b0;
      w_nx     = 1'b0;
      w_uf     = 1'b0;
    end else if (w_of) begin
      w_result = {r_sign, (w_use_max ? MAG_MAX_FINITE : MAG_INF)};
    end
  end

  assign ex3_vld     = r_ex3_vld;
  assign ex3_result  = r_ex3_vld ? w_result : 32'd0;
  assign ex3_flag_of = r_ex3_vld & w_of;
  assign ex3_flag_uf = r_ex3_vld & w_uf;
  assign ex3_flag_nx = r_ex3_vld & w_nx;

endmodule
